rx_frame_sampler: RTL and testbench

- UART receive front end, directly upstream of the RX paralleliser.
- Oversamples the already-synchronised RX line and majority-votes each bit.
- Sequences start / data / optional parity / stop bits.
- Drives the paralleliser's serial bit, bit tick and enable, and flags framing errors.

---
 rtl/rx_frame_sampler.sv | 198 +++++++++++++++++++
 tb/tb_rx_frame_sampler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_sampler.sv
// UART receive front end: oversamples RX_IN, votes each bit, and sequences
// start / data / optional parity / stop for the downstream paralleliser.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line idle, edge counter parked at 0, waiting for a low sample
// S_START  | inside the start bit; a high vote is a glitch and aborts
// S_DATA   | DATA_WIDTH data bits, LSB first, one vote per bit
// S_PARITY | parity bit present for this frame; vote goes to PAR_BIT
// S_STOP   | stop bit; leaves at the vote so the next start is caught
module rx_frame_sampler #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic RX_IN,
  input  logic OS_TICK,
  input  logic PAR_EN,
  output logic SER_DATA,
  output logic RX_TICK,
  output logic DATA_EN,
  output logic PAR_BIT,
  output logic PAR_VALID,
  output logic FRAME_DONE,
  output logic STOP_ERR,
  output logic START_GLITCH,
  output logic BUSY
);

  localparam int MID = PRESCALE / 2;
  localparam int EW  = $clog2(PRESCALE);
  localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] EDGE_S0   = EW'(MID - 1);
  localparam logic [EW-1:0] EDGE_S1   = EW'(MID);
  localparam logic [EW-1:0] EDGE_VOTE = EW'(MID + 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            s0_q, s0_d;
  logic            s1_q, s1_d;
  logic            par_en_q, par_en_d;
  logic            ser_data_q, ser_data_d;
  logic            rx_tick_q, rx_tick_d;
  logic            data_en_q, data_en_d;
  logic            par_bit_q, par_bit_d;
  logic            par_valid_q, par_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            stop_err_q, stop_err_d;
  logic            start_glitch_q, start_glitch_d;
  logic            busy_q, busy_d;

  logic at_vote;
  logic at_last;
  logic vote;

  assign at_vote = (edge_cnt_q == EDGE_VOTE);
  assign at_last = (edge_cnt_q == EDGE_LAST);
  assign vote    = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);

  always_comb begin
    state_d        = state_q;
    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    s0_d           = s0_q;
    s1_d           = s1_q;
    par_en_d       = par_en_q;
    ser_data_d     = ser_data_q;
    par_bit_d      = par_bit_q;
    rx_tick_d      = 1'b0;
    par_valid_d    = 1'b0;
    frame_done_d   = 1'b0;
    stop_err_d     = 1'b0;
    start_glitch_d = 1'b0;

    if (OS_TICK) begin
      if (state_q != S_IDLE) begin
        edge_cnt_d = at_last ? '0 : edge_cnt_q + 1'b1;
        if (edge_cnt_q == EDGE_S0) s0_d = RX_IN;
        if (edge_cnt_q == EDGE_S1) s1_d = RX_IN;
        if (at_vote) begin
          ser_data_d = vote;
          rx_tick_d  = 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          edge_cnt_d = '0;
          // The detecting tick is edge 0 of the start bit.
          if (!RX_IN) begin
            state_d    = S_START;
            edge_cnt_d = EW'(1);
            par_en_d   = PAR_EN;
          end
        end
        S_START: begin
          if (at_vote && vote) begin
            start_glitch_d = 1'b1;
            state_d        = S_IDLE;
            edge_cnt_d     = '0;
          end else if (at_last) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          if (at_last) begin
            if (bit_cnt_q == BIT_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
            else                       bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (at_vote) begin
            par_bit_d   = vote;
            par_valid_d = 1'b1;
          end
          if (at_last) state_d = S_STOP;
        end
        S_STOP: begin
          // Leave half a bit early so a back-to-back start edge is seen.
          if (at_vote) begin
            frame_done_d = 1'b1;
            stop_err_d   = ~vote;
            state_d      = S_IDLE;
            edge_cnt_d   = '0;
          end
        end
        default: begin
          state_d    = S_IDLE;
          edge_cnt_d = '0;
        end
      endcase
    end

    data_en_d = (state_d == S_DATA);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      par_en_q       <= 1'b0;
      ser_data_q     <= 1'b0;
      rx_tick_q      <= 1'b0;
      data_en_q      <= 1'b0;
      par_bit_q      <= 1'b0;
      par_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      stop_err_q     <= 1'b0;
      start_glitch_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      par_en_q       <= par_en_d;
      ser_data_q     <= ser_data_d;
      rx_tick_q      <= rx_tick_d;
      data_en_q      <= data_en_d;
      par_bit_q      <= par_bit_d;
      par_valid_q    <= par_valid_d;
      frame_done_q   <= frame_done_d;
      stop_err_q     <= stop_err_d;
      start_glitch_q <= start_glitch_d;
      busy_q         <= busy_d;
    end
  end

  assign SER_DATA     = ser_data_q;
  assign RX_TICK      = rx_tick_q;
  assign DATA_EN      = data_en_q;
  assign PAR_BIT      = par_bit_q;
  assign PAR_VALID    = par_valid_q;
  assign FRAME_DONE   = frame_done_q;
  assign STOP_ERR     = stop_err_q;
  assign START_GLITCH = start_glitch_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_rx_frame_sampler.sv
// Scoreboard bench for rx_frame_sampler: frames are described as per-oversample
// line levels, expected votes are majorities of the centre samples of each bit.
module tb_rx_frame_sampler;

  localparam int PRESCALE = 8;
  localparam int DW       = 8;
  localparam int MID      = PRESCALE / 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RX_IN = 1'b1;
  logic OS_TICK = 1'b0;
  logic PAR_EN = 1'b0;
  logic SER_DATA, RX_TICK, DATA_EN, PAR_BIT, PAR_VALID;
  logic FRAME_DONE, STOP_ERR, START_GLITCH, BUSY;

  rx_frame_sampler #(.PRESCALE(PRESCALE), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .OS_TICK(OS_TICK), .PAR_EN(PAR_EN),
    .SER_DATA(SER_DATA), .RX_TICK(RX_TICK), .DATA_EN(DATA_EN), .PAR_BIT(PAR_BIT),
    .PAR_VALID(PAR_VALID), .FRAME_DONE(FRAME_DONE), .STOP_ERR(STOP_ERR),
    .START_GLITCH(START_GLITCH), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ser;
    logic       den;
    logic       pv;
    logic       pb;
    logic       fd;
    logic       se;
    logic       sg;
    logic [7:0] dbyte;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] asm_byte = '0;
  bit         den_seen = 1'b0;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Monitor: pops one expectation per RX_TICK.
  initial begin
    exp_t       e;
    logic [5:0] act, req;
    forever begin
      @(negedge CLK);
      if (DATA_EN) den_seen = 1'b1;
      if (RX_TICK) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected: got tick with ser=%0b, required no tick", SER_DATA);
        end else begin
          e   = exp_q.pop_front();
          act = {SER_DATA, DATA_EN, PAR_VALID, FRAME_DONE, STOP_ERR, START_GLITCH};
          req = {e.ser, e.den, e.pv, e.fd, e.se, e.sg};
          if (act != req) begin
            errors++;
            $display("FAIL tick_fields {ser,den,pv,fd,se,sg}: got %b, required %b", act, req);
          end
          if (DATA_EN) asm_byte = {SER_DATA, asm_byte[7:1]};
          if (e.pv) begin
            checks++;
            if (PAR_BIT !== e.pb) begin
              errors++;
              $display("FAIL par_bit: got %0b, required %0b", PAR_BIT, e.pb);
            end
          end
          if (e.fd) begin
            checks++;
            if (asm_byte !== e.dbyte) begin
              errors++;
              $display("FAIL captured_byte: got %h, required %h", asm_byte, e.dbyte);
            end
          end
        end
      end else if (PAR_VALID | FRAME_DONE | STOP_ERR | START_GLITCH) begin
        checks++;
        errors++;
        $display("FAIL stray_pulse {pv,fd,se,sg}: got %b without RX_TICK, required 0000",
                 {PAR_VALID, FRAME_DONE, STOP_ERR, START_GLITCH});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One oversample period: OS_TICK high for one CLK, low for the next.
  task automatic slot(input logic v);
    @(posedge CLK); #1;
    RX_IN   = v;
    OS_TICK = 1'b1;
    @(posedge CLK); #1;
    OS_TICK = 1'b0;
  endtask

  task automatic idle_slots(input int n);
    for (int i = 0; i < n; i++) slot(1'b1);
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected ticks not seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Stop-bit level applies through the voting window; the line then returns
  // high for the last samples, as a real line does before the next start.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic stop_v, input bit rnd_noise,
                            input int nz_bit, input int nz_slot,
                            input int abort_bit, input int gap);
    logic bits [0:10];
    logic sl   [0:10][0:PRESCALE-1];
    int   nb, lo, hi, s;
    logic v;
    exp_t e;
    nb = pe ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (pe) bits[9] = pb;
    bits[nb-1] = stop_v;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < PRESCALE; k++)
        sl[b][k] = (b == nb-1 && k > MID + 1) ? 1'b1 : bits[b];
      if (rnd_noise && $urandom_range(1, 0) == 1) begin
        lo = (b == 0) ? 1 : 0;
        hi = (b == nb-1) ? MID + 1 : PRESCALE - 1;
        s  = $urandom_range(hi, lo);
        sl[b][s] = ~sl[b][s];
      end
      if (b == nz_bit) sl[b][nz_slot] = ~sl[b][nz_slot];
      v = maj(sl[b][MID-1], sl[b][MID], sl[b][MID+1]);
      e.ser   = v;
      e.den   = (b >= 1 && b <= 8);
      e.pv    = pe && (b == 9);
      e.pb    = v;
      e.fd    = (b == nb-1);
      e.se    = (b == nb-1) && !v;
      e.sg    = 1'b0;
      e.dbyte = d;
      exp_q.push_back(e);
    end
    PAR_EN = pe;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < PRESCALE; k++) begin
        if (b == abort_bit && k == 2) begin
          @(posedge CLK); #1;
          RST = 1'b1;
          OS_TICK = 1'b0;
          @(posedge CLK); #1;
          checks++;
          if ({BUSY, DATA_EN, RX_TICK, PAR_VALID, FRAME_DONE, STOP_ERR, START_GLITCH} != 7'b0) begin
            errors++;
            $display("FAIL reset_abort {busy,den,tick,pv,fd,se,sg}: got %b, required 0000000",
                     {BUSY, DATA_EN, RX_TICK, PAR_VALID, FRAME_DONE, STOP_ERR, START_GLITCH});
          end
          RST = 1'b0;
          exp_q.delete();
          idle_slots(PRESCALE + 2);
          return;
        end
        if (b == 2 && k == 0) begin
          check_bit("busy_mid_frame", BUSY, 1'b1);
          check_bit("data_en_mid_frame", DATA_EN, 1'b1);
        end
        slot(sl[b][k]);
        if (b == 0 && k == 0) PAR_EN = 1'b1 & $urandom_range(1, 0);
      end
    end
    check_drained("frame_ticks");
    idle_slots(gap);
  endtask

  task automatic send_glitch(input int low_slots);
    logic sl [0:2*PRESCALE-1];
    logic v;
    exp_t e;
    for (int k = 0; k < 2*PRESCALE; k++) sl[k] = (k < low_slots) ? 1'b0 : 1'b1;
    v = maj(sl[MID-1], sl[MID], sl[MID+1]);
    if (v) begin
      e = '0;
      e.ser = 1'b1;
      e.sg  = 1'b1;
      exp_q.push_back(e);
    end
    den_seen = 1'b0;
    for (int k = 0; k < 2*PRESCALE; k++) slot(sl[k]);
    check_drained("glitch_ticks");
    check_bit("glitch_no_data_en", den_seen, 1'b0);
    check_bit("glitch_idle", BUSY, 1'b0);
  endtask

  initial begin
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if ({SER_DATA, RX_TICK, DATA_EN, PAR_BIT, PAR_VALID, FRAME_DONE, STOP_ERR, START_GLITCH, BUSY} != 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 000000000",
               {SER_DATA, RX_TICK, DATA_EN, PAR_BIT, PAR_VALID, FRAME_DONE, STOP_ERR, START_GLITCH, BUSY});
    end
    RST = 1'b0;
    idle_slots(3);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, -1, 3);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, -1, 0, -1, 3);
    send_glitch(2);
    idle_slots(2);
    // Data bit 2 is frame bit index 3; flip only its edge 4.
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 3, MID, -1, 2);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1, 0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, -1, 2);
    // Data bit 3 is frame bit index 4.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, 4, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, -1, 2);

    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 ($urandom_range(7, 0) != 0), 1'b1, -1, 0, -1, $urandom_range(3, 0));
    end

    idle_slots(4);
    check_drained("final_drain");
    check_bit("final_idle", BUSY, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
